// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word-addressed strobes,
// read-modify-write for sub-word stores, sign/zero-extended loads.
// state | meaning: IDLE wait req | RD read strobe | WR word write | MERGE sub-word write | RSP response
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int ROM_DEPTH      = 256,
  parameter int RAM_DEPTH      = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [31:0]               req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0]     mem_w_data_o,
  input  logic [DATA_WIDTH-1:0]     mem_r_data_i,
  output logic                      mem_ctrl_w_o,
  output logic                      mem_ctrl_r_o
);

  localparam int AW = MEM_ADDR_WIDTH + 2;
  localparam logic [MEM_ADDR_WIDTH:0] LIMIT   = (MEM_ADDR_WIDTH+1)'(ROM_DEPTH + RAM_DEPTH);
  localparam logic [MEM_ADDR_WIDTH:0] ROM_END = (MEM_ADDR_WIDTH+1)'(ROM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_MERGE, S_RSP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept;
  logic                  req_err;
  logic [MEM_ADDR_WIDTH:0] req_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign accept   = req_valid_i && (state_q == S_IDLE);
  assign req_word = {1'b0, req_addr_i[AW-1:2]};

  always_comb begin
    req_err = 1'b0;
    if (req_size_i == 2'b11)                               req_err = 1'b1;
    if ((req_size_i == 2'b01) && req_addr_i[0])            req_err = 1'b1;
    if ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00)) req_err = 1'b1;
    if (req_addr_i[31:AW] != '0)                           req_err = 1'b1;
    if (req_word >= LIMIT)                                 req_err = 1'b1;
    if (req_we_i && (req_word < ROM_END))                  req_err = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= req_err;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i[AW-1:0];
        wdata_q <= req_wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_err)                                  state_d = S_RSP;
          else if (!req_we_i || (req_size_i != 2'b10))  state_d = S_RD;
          else                                          state_d = S_WR;
        end
      end
      S_RD:    state_d = we_q ? S_MERGE : S_RSP;
      S_WR:    state_d = S_RSP;
      S_MERGE: state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane selection uses the registered request; mem_r_data_i is valid in MERGE and RSP.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   byte_sel = mem_r_data_i[7:0];
      2'b01:   byte_sel = mem_r_data_i[15:8];
      2'b10:   byte_sel = mem_r_data_i[23:16];
      default: byte_sel = mem_r_data_i[31:24];
    endcase
    half_sel = addr_q[1] ? mem_r_data_i[31:16] : mem_r_data_i[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_r_data_i;
    endcase
  end

  always_comb begin
    merged = mem_r_data_i;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    req_ready_o   = (state_q == S_IDLE);
    mem_ctrl_r_o  = (state_q == S_RD);
    mem_ctrl_w_o  = (state_q == S_WR) || (state_q == S_MERGE);
    mem_address_o = addr_q[AW-1:2];
    mem_w_data_o  = '0;
    if (state_q == S_WR)    mem_w_data_o = wdata_q;
    if (state_q == S_MERGE) mem_w_data_o = merged;
    rsp_valid_o   = (state_q == S_RSP);
    rsp_error_o   = (state_q == S_RSP) && err_q;
    rsp_rdata_o   = '0;
    if ((state_q == S_RSP) && !we_q && !err_q) rsp_rdata_o = load_ext;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [9:0]  mem_address;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data = 32'h0;
  logic        mem_ctrl_w, mem_ctrl_r;

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, rdy_cnt = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  logic        b2b_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_error_o    (rsp_error),
    .mem_address_o  (mem_address),
    .mem_w_data_o   (mem_w_data),
    .mem_r_data_i   (mem_r_data),
    .mem_ctrl_w_o   (mem_ctrl_w),
    .mem_ctrl_r_o   (mem_ctrl_r)
  );

  always @(posedge clk) begin
    if (mem_ctrl_r) mem_r_data <= mem[mem_address];
    if (mem_ctrl_w) mem[mem_address] <= mem_w_data;
    else if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_ctrl_w) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= 32'(mem_address);
      last_wd <= mem_w_data;
    end
    if (mem_ctrl_r) rd_cnt <= rd_cnt + 1;
    if (mem_ctrl_r && mem_ctrl_w) both_cnt <= both_cnt + 1;
  end

  always @(negedge clk) if (b2b_on && req_ready) rdy_cnt <= rdy_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Called at a negedge; returns accept-to-response latency (0 = timed out).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    int guard;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_error; break; end
    end
  endtask

  task automatic err_case(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] a);
    int lat, r0, w0;
    logic [31:0] rd;
    logic er;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(we, sz, 1'b0, a, 32'hDEAD_BEEF, lat, rd, er);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, {31'd0, er}, 32'd1);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_nomem"}, 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
  endtask

  initial begin
    int lat, r0, w0, rdy0, guard;
    logic [31:0] rd;
    logic er;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    bd_write(10'd4,   32'h8765_4321);
    bd_write(10'd256, 32'h0000_F200);

    chk("rst_ready",  {31'd0, req_ready},  32'd1);
    chk("rst_rspv",   {31'd0, rsp_valid},  32'd0);
    chk("rst_rsperr", {31'd0, rsp_error},  32'd0);
    chk("rst_rdata",  rsp_rdata,           32'd0);
    chk("rst_strobe", {30'd0, mem_ctrl_w, mem_ctrl_r}, 32'd0);
    chk("rst_addr",   32'(mem_address),    32'd0);
    chk("rst_wdata",  mem_w_data,          32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    r0 = rd_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, '0, lat, rd, er);
    chk("lw_lat",   32'(lat), 32'd2);
    chk("lw_rdata", rd, 32'h8765_4321);
    chk("lw_err",   {31'd0, er}, 32'd0);
    chk("lw_reads", 32'(rd_cnt - r0), 32'd1);
    chk("lw_addr",  32'(mem_address), 32'd4);

    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0401, '0, lat, rd, er);
    chk("lb_rdata", rd, 32'hFFFF_FFF2);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0401, '0, lat, rd, er);
    chk("lbu_rdata", rd, 32'h0000_00F2);

    bd_write(10'd256, 32'h1122_3344);
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'h0000_BEEF, lat, rd, er);
    chk("sh_lat",    32'(lat), 32'd3);
    chk("sh_reads",  32'(rd_cnt - r0), 32'd1);
    chk("sh_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sh_waddr",  last_wa, 32'h100);
    chk("sh_wdata",  last_wd, 32'hBEEF_3344);
    chk("sh_rdata",  rd, 32'h0);
    chk("sh_err",    {31'd0, er}, 32'd0);

    err_case("e_lw_mis",  1'b0, 2'b10, 32'h0000_0402);
    err_case("e_sh_mis",  1'b1, 2'b01, 32'h0000_0001);
    err_case("e_size11",  1'b0, 2'b11, 32'h0000_0400);
    err_case("e_sw_rom",  1'b1, 2'b10, 32'h0000_0004);
    err_case("e_sb_rom",  1'b1, 2'b00, 32'h0000_03FF);
    err_case("e_lw_top",  1'b0, 2'b10, 32'h0000_0800);
    err_case("e_lw_high", 1'b0, 2'b10, 32'h0000_1000);
    err_case("e_lb_msb",  1'b0, 2'b00, 32'h8000_0400);

    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'h8001_7FFF, lat, rd, er);
    chk("sw_lat",    32'(lat), 32'd2);
    chk("sw_reads",  32'(rd_cnt - r0), 32'd0);
    chk("sw_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sw_wdata",  last_wd, 32'h8001_7FFF);
    chk("sw_waddr",  last_wa, 32'h101);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0406, '0, lat, rd, er);
    chk("lh_hi", rd, 32'hFFFF_8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0406, '0, lat, rd, er);
    chk("lhu_hi", rd, 32'h0000_8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0404, '0, lat, rd, er);
    chk("lh_lo", rd, 32'h0000_7FFF);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0407, 32'h0000_125A, lat, rd, er);
    chk("sb3_lat",   32'(lat), 32'd3);
    chk("sb3_wdata", last_wd, 32'h5A01_7FFF);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0405, 32'hFFFF_FFAB, lat, rd, er);
    chk("sb1_wdata", last_wd, 32'h5A01_ABFF);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0406, '0, lat, rd, er);
    chk("lb2_rdata", rd, 32'h0000_0001);

    // Reset while the sub-word write is pending in MERGE.
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0400; req_wdata = 32'h0000_0077;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("merge_w_pre", {31'd0, mem_ctrl_w}, 32'd1);
    w0 = wr_cnt;
    rst = 1'b1;
    #1;
    chk("rstm_strobe", {30'd0, mem_ctrl_w, mem_ctrl_r}, 32'd0);
    chk("rstm_ready",  {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rstm_rspv", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_rspv2",  {31'd0, rsp_valid}, 32'd0);
    chk("rstm_nowrite", 32'(wr_cnt - w0), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0400, '0, lat, rd, er);
    chk("post_rst_lat",   32'(lat), 32'd2);
    chk("post_rst_rdata", rd, 32'hBEEF_3344);

    // Back-to-back SW/LW pairs with req_valid held high.
    @(posedge clk);
    #1;
    rdy0 = rdy_cnt;
    b2b_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_we = (k % 2 == 0); req_size = 2'b10; req_unsigned = 1'b0;
      req_addr  = 32'h0000_0600 + 32'(4 * (k / 2));
      req_wdata = 32'hC0DE_0000 + 32'(k / 2);
      req_valid = 1'b1;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
      @(posedge clk);
      #1;
      lat = 0; rd = 'x;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        if (rsp_valid) begin lat = i; rd = rsp_rdata; break; end
      end
      chk($sformatf("b2b%0d_lat", k), 32'(lat), 32'd2);
      if (k % 2 == 1) chk($sformatf("b2b%0d_rdata", k), rd, 32'hC0DE_0000 + 32'(k / 2));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    b2b_on = 1'b0;
    chk("b2b_ready_cycles", 32'(rdy_cnt - rdy0), 32'd8);
    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
